// File: rtl/button_io.sv
// -----------------------------------------------------------------------------
// button_io
//   Four-button input block for a memory-mapped processor port. Each raw
//   button is synchronised, debounced, and turned into a sticky "pending"
//   press flag. A second press before the processor reads the flag sets a
//   sticky "overrun" flag. A processor load (rd_en) returns the flags and
//   clears them.
//
//   Every 4-bit field uses the bit order [0]=U, [1]=L, [2]=D, [3]=R.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a level
//                    change (>= 2)
//
// Ports
//   clock   in   1   system clock, all state changes on the rising edge
//   reset   in   1   synchronous active-high reset
//   BTNU    in   1   raw up button, active-high, asynchronous
//   BTNL    in   1   raw left button, active-high, asynchronous
//   BTND    in   1   raw down button, active-high, asynchronous
//   BTNR    in   1   raw right button, active-high, asynchronous
//   rd_en   in   1   processor load strobe, one cycle per load
//   q       out  32  read data: [3:0] pending, [7:4] stable, [11:8] overrun
//   stable  out  4   debounced button levels
// -----------------------------------------------------------------------------
module button_io #(
    parameter int DEBOUNCE_CYCLES = 400000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        BTNU,
    input  logic        BTNL,
    input  logic        BTND,
    input  logic        BTNR,
    input  logic        rd_en,
    output logic [31:0] q,
    output logic [3:0]  stable
);

    // Just wide enough to hold DEBOUNCE_CYCLES-1.
    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       raw;
    logic [3:0]       sync_meta;  // first synchroniser stage, may go metastable
    logic [3:0]       sync;       // second stage, the only copy the logic uses
    logic [CNT_W-1:0] count [4];
    logic [3:0]       pending;
    logic [3:0]       overrun;
    logic [3:0]       commit;     // stable takes the synchronised level this edge
    logic [3:0]       press;      // commit of a 0->1 change

    assign raw = {BTNR, BTND, BTNL, BTNU};

    // A bit commits once its synchronised level has differed from stable on
    // DEBOUNCE_CYCLES consecutive edges: the counter has already seen
    // DEBOUNCE_CYCLES-1 of them and this edge is the last.
    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional assignment, so no path can leave it unassigned and
        // infer a latch.
        commit = '0;
        for (int i = 0; i < 4; i++) begin
            commit[i] = (sync[i] != stable[i]) && (count[i] == CNT_MAX);
        end
    end

    // When a bit commits, the new level is sync; a new level of 1 is a press.
    assign press = commit & sync;

    always_ff @(posedge clock) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every register samples the pre-edge values, whatever the statement
        // order inside this block.
        if (reset) begin
            sync_meta <= '0;
            sync      <= '0;
            stable    <= '0;
            pending   <= '0;
            overrun   <= '0;
            // NOTE: the debounce counters are a small set of flops, not a RAM,
            // so clearing them on reset is cheap and keeps a partial count
            // from surviving the reset.
            for (int i = 0; i < 4; i++) begin
                count[i] <= '0;
            end
        end else begin
            sync_meta <= raw;
            sync      <= sync_meta;

            // Any cycle where sync matches stable restarts the count, so a
            // glitch shorter than DEBOUNCE_CYCLES never reaches a commit.
            for (int i = 0; i < 4; i++) begin
                if ((sync[i] == stable[i]) || commit[i]) begin
                    count[i] <= '0;
                end else begin
                    count[i] <= count[i] + CNT_W'(1);
                end
            end

            stable <= stable ^ commit;

            // A read clears every flag, except that a press on the same edge
            // leaves its pending bit set and its overrun bit clear.
            if (rd_en) begin
                pending <= press;
                overrun <= '0;
            end else begin
                overrun <= overrun | (press & pending);
                pending <= pending | press;
            end
        end
    end

    // Purely from registers, so the data is valid in the rd_en cycle itself.
    assign q = {20'd0, overrun, stable, pending};

endmodule

// File: tb/tb_button_io.sv
// -----------------------------------------------------------------------------
// tb_button_io
//   Scoreboard bench for button_io with DEBOUNCE_CYCLES = 4. Each applied
//   cycle pushes the reference model's expected {q, stable} into a queue. A
//   separate monitor pops one entry after each clock edge and compares it
//   with the DUT.
//
//   The reference model keeps a short history of raw samples and a window of
//   the last N synchronised levels. A bit commits when the whole window
//   disagrees with its stable level. Directed scenarios also check a few
//   absolute q values.
// -----------------------------------------------------------------------------
module tb_button_io;

    localparam int N = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        BTNU  = 1'b0;
    logic        BTNL  = 1'b0;
    logic        BTND  = 1'b0;
    logic        BTNR  = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] q;
    logic [3:0]  stable;

    button_io #(.DEBOUNCE_CYCLES(N)) dut (
        .clock  (clock),
        .reset  (reset),
        .BTNU   (BTNU),
        .BTNL   (BTNL),
        .BTND   (BTND),
        .BTNR   (BTNR),
        .rd_en  (rd_en),
        .q      (q),
        .stable (stable)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0] q;
        logic [3:0]  stable;
    } resp_t;

    resp_t exp_q[$];

    // ---------------- reference model ----------------
    logic [3:0] raw_hist[$];   // raw samples from the last two non-reset edges
    logic [3:0] sync_win[$];   // synchronised levels seen on the last N edges
    logic [3:0] m_stable = '0;
    logic [3:0] m_pend   = '0;
    logic [3:0] m_ovr    = '0;

    function automatic void model_edge(input logic rst, input logic [3:0] btn,
                                       input logic rd);
        logic [3:0] seen;
        logic [3:0] pressed;
        bit         all_differ;
        if (rst) begin
            raw_hist.delete();
            sync_win.delete();
            m_stable = '0;
            m_pend   = '0;
            m_ovr    = '0;
            return;
        end
        // The logic sees the raw level from two edges back (zero just after reset).
        seen = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size() - 2] : 4'b0000;
        raw_hist.push_back(btn);
        if (raw_hist.size() > 2) void'(raw_hist.pop_front());
        sync_win.push_back(seen);
        if (sync_win.size() > N) void'(sync_win.pop_front());

        pressed = '0;
        for (int b = 0; b < 4; b++) begin
            if (sync_win.size() == N) begin
                all_differ = 1'b1;
                foreach (sync_win[i]) begin
                    if (sync_win[i][b] == m_stable[b]) all_differ = 1'b0;
                end
                if (all_differ) begin
                    if (m_stable[b] == 1'b0) pressed[b] = 1'b1;
                    m_stable[b] = ~m_stable[b];
                end
            end
        end

        for (int b = 0; b < 4; b++) begin
            if (pressed[b]) begin
                if (rd) begin
                    m_pend[b] = 1'b1;
                    m_ovr[b]  = 1'b0;
                end else begin
                    if (m_pend[b]) m_ovr[b] = 1'b1;
                    m_pend[b] = 1'b1;
                end
            end else if (rd) begin
                m_pend[b] = 1'b0;
                m_ovr[b]  = 1'b0;
            end
        end
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and queue the state expected after its edge.
    task automatic step(input logic rst, input logic [3:0] btn, input logic rd);
        resp_t r;
        @(negedge clock);
        reset = rst;
        {BTNR, BTND, BTNL, BTNU} = btn;
        rd_en = rd;
        model_edge(rst, btn, rd);
        r.q      = {20'd0, m_ovr, m_stable, m_pend};
        r.stable = m_stable;
        exp_q.push_back(r);
    endtask

    task automatic hold(input logic [3:0] btn, input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, btn, 1'b0);
    endtask

    // Wait until just after the edge belonging to the last step.
    task automatic settle();
        @(posedge clock);
        #2;
    endtask

    // Monitor: one expected response per applied edge.
    initial begin
        resp_t r;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() != 0) begin
                r = exp_q.pop_front();
                check("q", q, r.q);
                check("stable", {28'd0, stable}, {28'd0, r.stable});
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] lvl;
        int         left [4];

        // Clean press on BTNL: committed on the 6th edge counting the sampling edge.
        step(1'b1, 4'b0000, 1'b0);
        hold(4'b0010, 5);
        settle();
        check("clean_press_early", q, 32'h0000_0000);
        hold(4'b0010, 1);
        settle();
        check("clean_press", q, 32'h0000_0022);

        // Glitch reject: three-cycle pulse on BTNU never commits.
        step(1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'b0001, 1'b0);
            settle();
            check("glitch_q", q, 32'h0);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 4'b0000, 1'b0);
            settle();
            check("glitch_q", q, 32'h0);
            check("glitch_stable", {28'd0, stable}, 32'h0);
        end

        // Read clear with BTNU held.
        step(1'b1, 4'b0000, 1'b0);
        hold(4'b0001, 6);
        settle();
        check("read_before", q, 32'h0000_0011);
        step(1'b0, 4'b0001, 1'b1);
        #1;
        check("read_during", q, 32'h0000_0011);
        settle();
        check("read_after", q, 32'h0000_0010);
        step(1'b0, 4'b0001, 1'b1);
        settle();
        check("read_again", q, 32'h0000_0010);

        // Overrun, then a press committing on a read edge.
        step(1'b1, 4'b0000, 1'b0);
        hold(4'b0100, 6);
        hold(4'b0000, 6);
        settle();
        check("release_keeps_pending", q, 32'h0000_0004);
        hold(4'b0100, 6);
        settle();
        check("overrun", q, 32'h0000_0444);
        hold(4'b0000, 6);
        hold(4'b0100, 5);
        step(1'b0, 4'b0100, 1'b1);
        settle();
        check("press_on_read", q, 32'h0000_0044);

        // Reset mid-count with all pending set; BTNR held through release.
        step(1'b1, 4'b0000, 1'b0);
        hold(4'b1111, 6);
        hold(4'b0000, 6);
        settle();
        check("all_pending", q, 32'h0000_000F);
        hold(4'b1000, 3);
        step(1'b1, 4'b1000, 1'b1);
        settle();
        check("reset_clears", q, 32'h0);
        hold(4'b1000, 5);
        settle();
        check("held_through_reset_early", q, 32'h0);
        hold(4'b1000, 1);
        settle();
        check("held_through_reset", q, 32'h0000_0088);

        // Randomised phase: per-button levels held for 1..8 cycles, so both
        // glitches and real presses occur; random reads and rare resets.
        lvl = '0;
        for (int b = 0; b < 4; b++) left[b] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if (left[b] == 0) begin
                    lvl[b]  = 1'($urandom_range(0, 1));
                    left[b] = int'($urandom_range(1, 8));
                end
                left[b]--;
            end
            step(($urandom_range(0, 199) == 0), lvl, ($urandom_range(0, 4) == 0));
        end

        repeat (3) @(posedge clock);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
